// File: rtl/decryptor_if.sv
// Ready/valid bundle between the encrypted-value memory side, the decryptor and its consumer.
// The master modport is the side that feeds ciphertext and consumes results.
interface decryptor_if;
  logic       InValid;
  logic       InReady;
  logic [7:0] Encrypted;
  logic [3:0] Key;
  logic       OutValid;
  logic       OutReady;
  logic [3:0] NumOut;
  logic       Error;

  modport master (
    output InValid, Encrypted, Key, OutReady,
    input  InReady, OutValid, NumOut, Error
  );

  modport slave (
    input  InValid, Encrypted, Key, OutReady,
    output InReady, OutValid, NumOut, Error
  );
endinterface

// File: rtl/decryptor.sv
// Nibble decryptor: restoring divide of the ciphertext by the key (one quotient bit per
// cycle), legality check on quotient/remainder, then a 2-bit left rotation of the quotient.
module decryptor (
  input  logic        clock,
  input  logic        reset,
  decryptor_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] d_q, d_d;
  logic [3:0] k_q, k_d;
  logic [4:0] r_q, r_d;
  logic [3:0] cnt_q, cnt_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic [3:0] num_q, num_d;
  logic       err_q, err_d;

  logic [4:0] trial_s;
  logic [4:0] diff_s;
  logic       fin_err_s;

  function automatic logic [3:0] rotl2(input logic [3:0] v);
    return {v[1:0], v[3:2]};
  endfunction

  // Restoring-divider datapath and the result legality test
  always_comb begin
    trial_s   = {r_q[3:0], d_q[7]};
    diff_s    = trial_s - {1'b0, k_q};
    // A zero key reaches FIN without dividing, so it is flagged here as well
    fin_err_s = (r_q != 5'd0) | (d_q[7:4] != 4'd0) | (k_q == 4'd0);
  end

  // Next-state logic for the control FSM, divider registers and result registers
  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    k_d         = k_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    num_d       = num_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.InValid) begin
          d_d        = bus.Encrypted;
          k_d        = bus.Key;
          r_d        = 5'd0;
          cnt_d      = 4'd8;
          in_ready_d = 1'b0;
          if (bus.Key == 4'd0) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_DIV;
          end
        end else begin
          in_ready_d = 1'b1;
        end
      end
      ST_DIV: begin
        if (trial_s >= {1'b0, k_q}) begin
          r_d = diff_s;
          d_d = {d_q[6:0], 1'b1};
        end else begin
          r_d = trial_s;
          d_d = {d_q[6:0], 1'b0};
        end
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_FIN: begin
        err_d       = fin_err_s;
        num_d       = fin_err_s ? 4'd0 : rotl2(d_q[3:0]);
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (bus.OutReady) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      d_q         <= 8'd0;
      k_q         <= 4'd0;
      r_q         <= 5'd0;
      cnt_q       <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      num_q       <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      k_q         <= k_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      num_q       <= num_d;
      err_q       <= err_d;
    end
  end

  assign bus.InReady  = in_ready_q;
  assign bus.OutValid = out_valid_q;
  assign bus.NumOut   = num_q;
  assign bus.Error    = err_q;

endmodule
